// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// No logic beyond two tiny op-decode helpers.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    localparam int          MD_ITER     = 32;
    localparam logic [31:0] MD_DIV0_QUO = 32'hFFFF_FFFF;

    // op[0]=0 selects the signed variant, op[1]=1 selects division.
    function automatic logic md_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] o);
        return o[1];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix32.sv
// Conditional two's-complement negation; used as |x| on operand entry and as result sign fix on exit.
// Purely combinational, zero latency, no flow control.
module sign_fix32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Latency 33 cycles start-to-done; start is ignored while busy (no queuing), cancel aborts without writing HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] mag_b;
    logic [31:0] a_raw;
    logic        op_div;
    logic        neg_q;
    logic        neg_rem;
    logic        div_zero;

    logic        sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign sgn = md_is_signed(op);

    sign_fix32 #(.WIDTH(32)) u_abs_a (
        .val (src_a),
        .neg (sgn & src_a[31]),
        .res (abs_a)
    );

    sign_fix32 #(.WIDTH(32)) u_abs_b (
        .val (src_b),
        .neg (sgn & src_b[31]),
        .res (abs_b)
    );

    // Quotient and product share the "operand signs differ" flag.
    sign_fix32 #(.WIDTH(64)) u_fix_prod (
        .val (acc),
        .neg (neg_q),
        .res (prod_fix)
    );

    sign_fix32 #(.WIDTH(32)) u_fix_quo (
        .val (acc[31:0]),
        .neg (neg_q),
        .res (quo_fix)
    );

    sign_fix32 #(.WIDTH(32)) u_fix_rem (
        .val (acc[63:32]),
        .neg (neg_rem),
        .res (rem_fix)
    );

    // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ge    = (div_shift >= {1'b0, mag_b});
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 6'd0;
            acc      <= 64'd0;
            mag_b    <= 32'd0;
            a_raw    <= 32'd0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !cancel) begin
                        cnt      <= 6'd0;
                        op_div   <= md_is_div(op);
                        a_raw    <= src_a;
                        neg_q    <= sgn & (src_a[31] ^ src_b[31]);
                        neg_rem  <= sgn & src_a[31];
                        div_zero <= md_is_div(op) && (src_b == 32'd0);
                        if (md_is_div(op)) begin
                            acc   <= {32'd0, abs_a};
                            mag_b <= abs_b;
                            state <= ST_DIV;
                        end else begin
                            acc   <= {32'd0, abs_b};
                            mag_b <= abs_a;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        busy <= 1'b1;
                        acc  <= (state == ST_MUL) ? mul_next : div_next;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'(MD_ITER - 1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (div_zero) begin
                            hi <= a_raw;
                            lo <= MD_DIV0_QUO;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO and cycle-accurate busy/done checks.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Observe 40 edges after start; counts are bounded so a stuck DUT still ends here.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cnt;
        int done_cnt;
        int done_edge;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        cycle();
        start = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge == 0) done_edge = e;
            end
        end
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd32);
        chk({tag, ".done_edge"}, 64'(done_edge), 64'd33);
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic watch_idle(input string tag, input int n);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        for (int e = 0; e < n; e++) begin
            cycle();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd0);
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = MD_MULT;
        src_a    = 32'd0;
        src_b    = 32'd0;
        cancel   = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = 32'd0;

        cycle();
        cycle();
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        cycle();

        run_op("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg_neg", MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_m5_0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // mthi, then multu cancelled at edge 10 with ignored start and mthi during busy.
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        cycle();
        hi_we = 1'b0;
        chk("mthi.hi", 64'(hi), 64'h1234);
        op    = MD_MULTU;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        op    = MD_MULT;
        src_a = 32'd100;
        src_b = 32'd100;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
        cycle();
        hi_we = 1'b0;
        repeat (4) cycle();
        chk("cancel.busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        chk("cancel.busy_after", 64'(busy), 64'd0);
        watch_idle("cancel.quiet", 40);
        chk("cancel.hi", 64'(hi), 64'h1234);
        chk("cancel.lo", 64'(lo), 64'h8000_0000);

        // cancel in IDLE swallows a same-cycle start.
        op     = MD_MULTU;
        src_a  = 32'd9;
        src_b  = 32'd9;
        start  = 1'b1;
        cancel = 1'b1;
        cycle();
        start  = 1'b0;
        cancel = 1'b0;
        watch_idle("idle_cancel", 40);
        chk("idle_cancel.lo", 64'(lo), 64'h8000_0000);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_A5A5;
        cycle();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthilo.hi", 64'(hi), 64'hA5A5);
        chk("mthilo.lo", 64'(lo), 64'hA5A5);

        // mtlo and start together: the write lands, then the product overwrites it.
        lo_we = 1'b1;
        wdata = 32'h0000_0055;
        op    = MD_MULTU;
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        cycle();
        lo_we = 1'b0;
        start = 1'b0;
        chk("mtlo_start.lo_early", 64'(lo), 64'h55);
        repeat (34) cycle();
        chk("mtlo_start.hi", 64'(hi), 64'd0);
        chk("mtlo_start.lo", 64'(lo), 64'd42);

        // Reset in the middle of a divide.
        hi_we = 1'b1;
        wdata = 32'h0000_BEEF;
        cycle();
        hi_we = 1'b0;
        op    = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (19) cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.hi", 64'(hi), 64'd0);
        chk("rst_mid.lo", 64'(lo), 64'd0);
        cycle();
        rst_n = 1'b1;
        watch_idle("rst_mid.quiet", 40);
        run_op("post_rst_mult", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
